mem_access_unit: RTL

Load/store front end placed directly upstream of the data RAM in the multi-cycle MIPS datapath. Accepts byte-addressed CPU requests of byte, halfword or word size and checks alignment and range. Drives the word-addressed RAM port: combinational read, write on the clock edge. Returns sign- or zero-extended load data, and turns sub-word stores into a read-modify-write sequence.

---
 rtl/mem_access_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types and constants for the load/store front end.
//   mem_size_e  : request access size encoding (byte/half/word/reserved)
//   mau_state_e : control FSM states of mem_access_unit
//   *_W         : lane widths in bits
//   is_subword  : true for sizes that need a read-modify-write on store
package mem_access_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } mau_state_e;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  function automatic logic is_subword(input mem_size_e size);
    return (size == MEM_BYTE) || (size == MEM_HALF);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Purely combinational big-endian lane handling.
//   word_i   : 32-bit word read from RAM
//   size_i   : access size
//   off_i    : byte offset within the word (addr[1:0])
//   signed_i : 1 = sign-extend the extracted lane, 0 = zero-extend
//   wdata_i  : right-justified store data
//   load_o   : extracted and extended lane (0 for reserved size)
//   merged_o : word_i with the addressed lane replaced by wdata_i
// Big-endian: byte offset b selects [31-8b -: 8], half offset h = off[1]
// selects [31-16h -: 16].
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  mem_size_e         size_i,
  input  logic [1:0]        off_i,
  input  logic              signed_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  always_comb begin
    byte_lane = '0;
    half_lane = '0;
    load_o    = '0;
    merged_o  = word_i;

    case (off_i)
      2'd0:    byte_lane = word_i[31:24];
      2'd1:    byte_lane = word_i[23:16];
      2'd2:    byte_lane = word_i[15:8];
      default: byte_lane = word_i[7:0];
    endcase
    half_lane = off_i[1] ? word_i[15:0] : word_i[31:16];

    case (size_i)
      MEM_BYTE: begin
        load_o = {{(WORD_W-BYTE_W){signed_i & byte_lane[BYTE_W-1]}}, byte_lane};
        case (off_i)
          2'd0:    merged_o[31:24] = wdata_i[7:0];
          2'd1:    merged_o[23:16] = wdata_i[7:0];
          2'd2:    merged_o[15:8]  = wdata_i[7:0];
          default: merged_o[7:0]   = wdata_i[7:0];
        endcase
      end
      MEM_HALF: begin
        load_o = {{(WORD_W-HALF_W){signed_i & half_lane[HALF_W-1]}}, half_lane};
        if (off_i[1]) merged_o[15:0]  = wdata_i[15:0];
        else          merged_o[31:16] = wdata_i[15:0];
      end
      MEM_WORD: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
      default: begin
        load_o   = '0;
        merged_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store front end sitting directly in front of a word-addressed data
// RAM (combinational read, write on posedge). Checks alignment/range/size,
// returns extended load data and performs sub-word stores as
// read-modify-write.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (see below)
//   req_we, req_size,
//   req_signed, req_addr,
//   req_wdata            : request fields, sampled on acceptance
//   rsp_valid            : one-cycle completion pulse
//   rsp_rdata, rsp_err   : response payload, held until the next response
//   ram_addr, ram_wr_data,
//   ram_wr_en, ram_rd_data: RAM port
//   dbg_state_o          : current FSM state
//
// Handshake: a request transfers on a clock edge where req_valid &&
// req_ready; req_ready is high only in IDLE. The response has no
// backpressure: rsp_valid is high for exactly one cycle per accepted
// request and the consumer must take it then.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [WORD_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [WORD_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_W-1:0]         ram_wr_data,
  output logic                      ram_wr_en,
  input  logic [WORD_W-1:0]         ram_rd_data,
  output mau_state_e                dbg_state_o
);

  // Byte-address bits that map into the RAM; anything above must be zero.
  localparam int LOW_W = RAM_ADDR_WIDTH + 2;

  mau_state_e          state_q, state_d;
  logic                we_q, we_d;
  mem_size_e           size_q, size_d;
  logic                signed_q, signed_d;
  logic [LOW_W-1:0]    addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   merge_q, merge_d;
  logic [WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  mem_size_e           req_size_e;
  logic                req_bad;
  logic                wr_en;
  logic [WORD_W-1:0]   load_data;
  logic [WORD_W-1:0]   merged_data;

  assign req_size_e = mem_size_e'(req_size);

  // Request check on the live request fields, used in the accept cycle.
  always_comb begin
    req_bad = |req_addr[ADDR_WIDTH-1:LOW_W];
    case (req_size_e)
      MEM_HALF: req_bad = req_bad | req_addr[0];
      MEM_WORD: req_bad = req_bad | (|req_addr[1:0]);
      MEM_RSVD: req_bad = 1'b1;
      default:  ;
    endcase
  end

  mem_lane_align u_align (
    .word_i   (ram_rd_data),
    .size_i   (size_q),
    .off_i    (addr_q[1:0]),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merged_o (merged_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= MEM_BYTE;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      merge_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    wr_en       = 1'b0;
    ram_wr_data = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size_e;
          signed_d = req_signed;
          addr_d   = req_addr[LOW_W-1:0];
          wdata_d  = req_wdata;
          if (req_bad) begin
            // Response payload is loaded on the edge that enters RESP so
            // rsp_rdata/rsp_err change together with rsp_valid.
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (!is_subword(size_q)) begin
          wr_en       = 1'b1;
          ram_wr_data = wdata_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          merge_d = merged_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_en       = 1'b1;
        ram_wr_data = merge_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The reset gate keeps a write from landing in a cycle where the access
  // is being aborted.
  assign ram_wr_en   = wr_en & ~rst;
  assign ram_addr    = addr_q[LOW_W-1:2];
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule
